// File: rtl/tiny_alu_requester.sv
// Command-side requester for tiny_alu: queues operation commands in a small FIFO,
// issues them one at a time over the start/done handshake and returns each result.
module tiny_alu_requester #(
   parameter int INPUT_DATA_BITS = 8,
   parameter int FIFO_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES  = 8,
   parameter int OPCODE_BITS     = 3
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           cmd_valid_i,
   output logic                           cmd_ready_o,
   input  logic [INPUT_DATA_BITS-1:0]     cmd_a_i,
   input  logic [INPUT_DATA_BITS-1:0]     cmd_b_i,
   input  logic [OPCODE_BITS-1:0]         cmd_opcode_i,
   output logic [INPUT_DATA_BITS-1:0]     alu_a_o,
   output logic [INPUT_DATA_BITS-1:0]     alu_b_o,
   output logic [OPCODE_BITS-1:0]         alu_opcode_o,
   output logic                           alu_start_o,
   input  logic [2*INPUT_DATA_BITS-1:0]   alu_result_i,
   input  logic                           alu_done_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [2*INPUT_DATA_BITS-1:0]   rsp_result_o,
   output logic                           rsp_err_o,
   output logic                           busy_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic [INPUT_DATA_BITS-1:0] fifo_a  [FIFO_DEPTH];
   logic [INPUT_DATA_BITS-1:0] fifo_b  [FIFO_DEPTH];
   logic [OPCODE_BITS-1:0]     fifo_op [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           count;
   logic [TMO_W-1:0]           timer;
   logic                       push;
   logic                       pop;

   // Ready comes from the registered count only, so a full FIFO refuses a push
   // even when the FSM pops in the same cycle.
   assign cmd_ready_o = (count != CNT_FULL);
   assign push        = cmd_valid_i && cmd_ready_o;
   assign alu_start_o = (state == S_ISSUE);
   assign rsp_valid_o = (state == S_RESP);
   assign busy_o      = (state != S_IDLE) || (count != '0);

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_a[wr_ptr]  <= cmd_a_i;
         fifo_b[wr_ptr]  <= cmd_b_i;
         fifo_op[wr_ptr] <= cmd_opcode_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) state <= S_IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = S_ISSUE;
            end
         end
         S_ISSUE: next_state = S_WAIT;
         S_WAIT: begin
            if (alu_done_i || (timer == TMO_LAST)) next_state = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready_i) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Operand registers hold the last issued command; result/err are only
   // written in WAIT so they stay stable for the whole RESP phase.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         alu_a_o      <= '0;
         alu_b_o      <= '0;
         alu_opcode_o <= '0;
         timer        <= '0;
         rsp_result_o <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         if (pop) begin
            alu_a_o      <= fifo_a[rd_ptr];
            alu_b_o      <= fifo_b[rd_ptr];
            alu_opcode_o <= fifo_op[rd_ptr];
         end
         if (state == S_ISSUE) begin
            timer <= '0;
         end else if (state == S_WAIT && !alu_done_i) begin
            timer <= timer + 1'b1;
         end
         if (state == S_WAIT) begin
            if (alu_done_i) begin
               rsp_result_o <= alu_result_i;
               rsp_err_o    <= 1'b0;
            end else if (timer == TMO_LAST) begin
               rsp_result_o <= '0;
               rsp_err_o    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tiny_alu_requester.sv
// Bench for tiny_alu_requester: behavioural ALU responder, response scoreboard,
// a table of single-op vectors, multi-cycle corner sequences and random traffic.
module tb_tiny_alu_requester;

   localparam int TIMEOUT = 8;
   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   typedef struct packed {
      logic [15:0] res;
      logic        err;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        err;
      int          lat;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic [15:0] alu_result;
   logic        alu_done;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_err;
   logic        busy;

   tiny_alu_requester #(
      .INPUT_DATA_BITS(8),
      .FIFO_DEPTH(4),
      .TIMEOUT_CYCLES(TIMEOUT),
      .OPCODE_BITS(3)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_a_i(cmd_a),
      .cmd_b_i(cmd_b),
      .cmd_opcode_i(cmd_op),
      .alu_a_o(alu_a),
      .alu_b_o(alu_b),
      .alu_opcode_o(alu_op),
      .alu_start_o(alu_start),
      .alu_result_i(alu_result),
      .alu_done_i(alu_done),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result),
      .rsp_err_o(rsp_err),
      .busy_o(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks = 0;
   int   errors = 0;
   int   alu_delay = 1;     // 0: delay from operands, 1..8: fixed, >8: never done
   bit   spurious = 1'b0;
   cmd_t cmd_q[$];
   exp_t exp_q[$];
   int   acc_n = 0;
   int   got_n = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic [15:0] got_r [256];
   logic        got_e [256];
   int          got_lat [256];
   bit   last_acc;
   bit   last_rsp;
   bit   gaps = 1'b0;
   bit   rand_ready = 1'b0;
   vec_t tbl [8];

   function automatic logic [15:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         OP_ADD:  return 16'(a) + 16'(b);
         OP_AND:  return 16'(a & b);
         OP_XOR:  return 16'(a ^ b);
         OP_MUL:  return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int delay_of(logic [7:0] a, logic [7:0] b, int dly);
      if (dly != 0) return dly;
      return 1 + ((int'(a) + int'(b)) % 9);
   endfunction

   function automatic exp_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b, int dly);
      exp_t r;
      if (op > OP_MUL || delay_of(a, b, dly) > TIMEOUT) begin
         r.res = 16'h0000;
         r.err = 1'b1;
      end else begin
         r.res = alu_fn(op, a, b);
         r.err = 1'b0;
      end
      return r;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // ALU responder: done arrives 'delay' cycles after the start pulse;
   // unknown opcodes and over-long delays never answer.
   int          pend = 0;
   int          cnt = 0;
   logic [7:0]  la = 8'h00;
   logic [7:0]  lb = 8'h00;
   logic [2:0]  lop = 3'd0;
   initial begin
      alu_done   = 1'b0;
      alu_result = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         alu_done = 1'b0;
         if (spurious) begin
            alu_done   = 1'b1;
            alu_result = 16'hDEAD;
         end else if (pend != 0) begin
            cnt--;
            if (cnt == 0) begin
               pend       = 0;
               alu_done   = 1'b1;
               alu_result = alu_fn(lop, la, lb);
            end
         end
         @(negedge clk);
         if (alu_start) begin
            la   = alu_a;
            lb   = alu_b;
            lop  = alu_op;
            cnt  = delay_of(la, lb, alu_delay);
            pend = (lop <= OP_MUL && cnt <= TIMEOUT) ? 1 : 0;
         end
      end
   end

   task automatic tick();
      exp_t e;
      @(negedge clk);
      last_acc = reset_n && cmd_valid && cmd_ready;
      last_rsp = reset_n && rsp_valid && rsp_ready;
      if (last_acc) begin
         exp_q.push_back(model(cmd_op, cmd_a, cmd_b, alu_delay));
         acc_n++;
         acc_cyc = cyc;
      end
      if (last_rsp) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=%0h required=none", rsp_result);
         end else begin
            e = exp_q.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
         end
         if (got_n < 256) begin
            got_r[got_n]   = rsp_result;
            got_e[got_n]   = rsp_err;
            got_lat[got_n] = cyc - acc_cyc;
         end
         got_n++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_step();
      if (!cmd_valid && cmd_q.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
         cmd_valid = 1'b1;
         cmd_op    = cmd_q[0].op;
         cmd_a     = cmd_q[0].a;
         cmd_b     = cmd_q[0].b;
      end
      if (rand_ready) rsp_ready = ($urandom_range(0, 1) == 1);
      tick();
      if (last_acc) begin
         void'(cmd_q.pop_front());
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain(int budget);
      int n = 0;
      while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         drive_step();
         n++;
      end
      check("drain_left", 32'(cmd_q.size() + exp_q.size()), 32'd0);
   endtask

   task automatic run_one(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      cmd_q.push_back('{op, a, b});
      drain(60);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      tbl[0] = '{OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b0, 4};
      tbl[1] = '{OP_AND, 8'hF0, 8'h3C, 16'h0030, 1'b0, 4};
      tbl[2] = '{OP_XOR, 8'hA5, 8'h5A, 16'h00FF, 1'b0, 4};
      tbl[3] = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 4};
      tbl[4] = '{OP_NOP, 8'h12, 8'h34, 16'h0000, 1'b0, 4};
      tbl[5] = '{OP_ADD, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 4};
      tbl[6] = '{3'd6,   8'h11, 8'h22, 16'h0000, 1'b1, 11};
      tbl[7] = '{OP_MUL, 8'h10, 8'h10, 16'h0100, 1'b0, 4};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_op    = 3'd0;
      rsp_ready = 1'b1;

      // Reset held for two edges
      tick();
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_start", 32'(alu_start), 32'd0);
      check("rst_alu_ops", 32'({alu_a, alu_b, alu_op}), 32'd0);
      check("rst_rsp", 32'({rsp_result, rsp_err}), 32'd0);
      reset_n = 1'b1;
      tick();

      // Single-op vectors: result, error flag and accept-to-response latency
      for (int k = 0; k < 8; k++) begin
         base = got_n;
         run_one(tbl[k].op, tbl[k].a, tbl[k].b);
         check("tbl_count", 32'(got_n), 32'(base + 1));
         check("tbl_result", 32'(got_r[base]), 32'(tbl[k].res));
         check("tbl_err", 32'(got_e[base]), 32'(tbl[k].err));
         check("tbl_latency", 32'(got_lat[base]), 32'(tbl[k].lat));
      end

      // Done on the last WAIT cycle still succeeds; one later times out
      alu_delay = 8;
      base = got_n;
      run_one(OP_ADD, 8'h20, 8'h22);
      check("dly8_result", 32'(got_r[base]), 32'h0042);
      check("dly8_err", 32'(got_e[base]), 32'd0);
      check("dly8_latency", 32'(got_lat[base]), 32'd11);

      alu_delay = 99;
      base = got_n;
      run_one(OP_ADD, 8'h07, 8'h09);
      check("tmo_result", 32'(got_r[base]), 32'h0000);
      check("tmo_err", 32'(got_e[base]), 32'd1);
      check("tmo_latency", 32'(got_lat[base]), 32'd11);
      alu_delay = 1;
      base = got_n;
      run_one(OP_ADD, 8'h02, 8'h03);
      check("after_tmo_result", 32'(got_r[base]), 32'h0005);
      check("after_tmo_err", 32'(got_e[base]), 32'd0);

      // Back-to-back commands come back in order
      base = got_n;
      cmd_q.push_back('{OP_MUL, 8'hFF, 8'hFF});
      cmd_q.push_back('{OP_XOR, 8'hA5, 8'h5A});
      cmd_q.push_back('{OP_NOP, 8'h77, 8'h88});
      drain(100);
      check("b2b_count", 32'(got_n), 32'(base + 3));
      check("b2b_0", 32'(got_r[base]), 32'hFE01);
      check("b2b_1", 32'(got_r[base + 1]), 32'h00FF);
      check("b2b_2", 32'(got_r[base + 2]), 32'h0000);

      // Response stall: one op in flight plus a full FIFO, then back-pressure
      rsp_ready = 1'b0;
      base = acc_n;
      for (int i = 0; i < 7; i++) cmd_q.push_back('{OP_ADD, 8'(i), 8'(3 * i)});
      for (int i = 0; i < 20; i++) drive_step();
      check("stall_accepted", 32'(acc_n - base), 32'd5);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_held", 32'(rsp_result), 32'h0000);
      check("stall_busy", 32'(busy), 32'd1);
      base = got_n;
      rsp_ready = 1'b1;
      drain(200);
      check("stall_rsp_count", 32'(got_n - base), 32'd7);

      // Stray done while a response is held, and while idle, is ignored
      rsp_ready = 1'b0;
      cmd_q.push_back('{OP_ADD, 8'h01, 8'h01});
      for (int i = 0; i < 20 && !rsp_valid; i++) drive_step();
      spurious = 1'b1;
      tick();
      spurious = 1'b0;
      tick();
      check("stray_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stray_rsp_result", 32'(rsp_result), 32'h0002);
      check("stray_rsp_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      drain(20);
      base = got_n;
      spurious = 1'b1;
      tick();
      spurious = 1'b0;
      tick();
      check("idle_stray_busy", 32'(busy), 32'd0);
      check("idle_stray_rsp", 32'(got_n), 32'(base));
      run_one(OP_ADD, 8'h03, 8'h04);
      check("idle_stray_next", 32'(got_r[base]), 32'h0007);

      // Random traffic against the scoreboard
      alu_delay  = 0;
      gaps       = 1'b1;
      rand_ready = 1'b1;
      base = got_n;
      for (int i = 0; i < 50; i++) begin
         cmd_q.push_back('{3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255))});
      end
      drain(4000);
      check("rand_rsp_count", 32'(got_n - base), 32'd50);
      gaps       = 1'b0;
      rand_ready = 1'b0;
      rsp_ready  = 1'b1;

      // Reset in WAIT with three commands queued: everything is dropped
      alu_delay = 99;
      for (int i = 0; i < 4; i++) cmd_q.push_back('{OP_ADD, 8'(i + 1), 8'h10});
      for (int i = 0; i < 6; i++) drive_step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_queued", 32'(cmd_q.size()), 32'd0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      exp_q.delete();
      base = got_n;
      for (int i = 0; i < 15; i++) tick();
      check("mid_rst_no_rsp", 32'(got_n), 32'(base));
      check("mid_rst_idle", 32'(busy), 32'd0);
      alu_delay = 1;
      run_one(OP_ADD, 8'h40, 8'h02);
      check("post_rst_result", 32'(got_r[base]), 32'h0042);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
